led_frame_ctrl: RTL and testbench

- Parametrised successor to the 16x16 red/green LED screen selector for the Flappy Bird game.
- Adds a three-mode screen FSM: START, PLAY and OVER.
- Also adds frame-synchronous, tear-free output registers, bird/pipe collision detection, a blinking game-over banner and a survived-frame score.
- Sits between the game logic (bird row, pipe field) and the LED matrix driver.

---
 rtl/flappy_pkg.sv | 30 +++
 rtl/led_blink_timer.sv | 44 ++++
 rtl/led_frame_ctrl.sv | 109 ++++++++++
 tb/tb_led_frame_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared types and banner images for the Flappy Bird LED screen.
// Each image is a 16x16 bitmap indexed [row][col], one packed word per row.
package flappy_pkg;

  typedef enum logic [1:0] {
    MODE_START = 2'd0,
    MODE_PLAY  = 2'd1,
    MODE_OVER  = 2'd2
  } mode_e;

  localparam int ROWS = 16;
  localparam int COLS = 16;

  // "GO" banner
  localparam logic [15:0][15:0] START_IMG = {
    16'h0000, 16'h0000, 16'h0000, 16'h3C3C,
    16'h4242, 16'h4042, 16'h4042, 16'h4E42,
    16'h4242, 16'h4242, 16'h3C3C, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000
  };

  // "X" banner
  localparam logic [15:0][15:0] OVER_IMG = {
    16'h8001, 16'h4002, 16'h2004, 16'h1008,
    16'h0810, 16'h0420, 16'h0240, 16'h0180,
    16'h0180, 16'h0240, 16'h0420, 16'h0810,
    16'h1008, 16'h2004, 16'h4002, 16'h8001
  };

endpackage

// File: rtl/led_blink_timer.sv
// Frame-tick driven blink phase generator with a saturating hold counter.
// The hold counter holds at HOLD_TICKS; hold_done is high while it sits there.
module led_blink_timer #(
  parameter int BLINK_TICKS = 4,
  parameter int HOLD_TICKS  = 8
) (
  input  logic Clock,
  input  logic RST,
  input  logic tick,
  input  logic clr,
  output logic phase,
  output logic hold_done
);

  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  logic [BW-1:0] blink_cnt;
  logic [HW-1:0] hold_cnt;

  always_ff @(posedge Clock or posedge RST) begin
    if (RST) begin
      blink_cnt <= '0;
      hold_cnt  <= '0;
      phase     <= 1'b0;
    end else if (clr) begin
      blink_cnt <= '0;
      hold_cnt  <= '0;
      phase     <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      if (hold_cnt != HW'(HOLD_TICKS))
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign hold_done = (hold_cnt == HW'(HOLD_TICKS));

endmodule

// File: rtl/led_frame_ctrl.sv
// Screen-mode FSM and frame-synchronous red/green LED planes for Flappy Bird.
// Planes reload only on frame_tick so the matrix driver never sees a torn frame.
module led_frame_ctrl
  import flappy_pkg::*;
#(
  parameter int ROWS        = flappy_pkg::ROWS,
  parameter int COLS        = flappy_pkg::COLS,
  parameter int BIRD_ROW    = 2,
  parameter int BLINK_TICKS = 4,
  parameter int HOLD_TICKS  = 8,
  parameter int SCORE_W     = 8,
  parameter logic [ROWS-1:0][COLS-1:0] START_IMG = flappy_pkg::START_IMG,
  parameter logic [ROWS-1:0][COLS-1:0] OVER_IMG  = flappy_pkg::OVER_IMG
) (
  input  logic                       Clock,
  input  logic                       RST,
  input  logic                       frame_tick,
  input  logic                       start_btn,
  input  logic [COLS-1:0]            birdie,
  input  logic [ROWS-1:0][COLS-1:0]  pipes,
  output logic [ROWS-1:0][COLS-1:0]  redled,
  output logic [ROWS-1:0][COLS-1:0]  greenled,
  output mode_e                      mode,
  output logic                       collision,
  output logic [SCORE_W-1:0]         score
);

  if (BIRD_ROW >= ROWS || BIRD_ROW < 0) begin : g_bad_bird_row
    $error("led_frame_ctrl: BIRD_ROW must be in 0..ROWS-1");
  end
  if (BLINK_TICKS < 1) begin : g_bad_blink
    $error("led_frame_ctrl: BLINK_TICKS must be >= 1");
  end
  if (HOLD_TICKS < 1) begin : g_bad_hold
    $error("led_frame_ctrl: HOLD_TICKS must be >= 1");
  end

  logic                      hit;
  logic                      phase;
  logic                      hold_done;
  logic [ROWS-1:0][COLS-1:0] play_red;

  assign hit = |(birdie & pipes[BIRD_ROW]);

  always_comb begin
    play_red           = '0;
    play_red[BIRD_ROW] = birdie;
  end

  // Timer counts only OVER ticks and restarts on the collision edge, so the
  // first OVER frame always shows the banner.
  led_blink_timer #(
    .BLINK_TICKS (BLINK_TICKS),
    .HOLD_TICKS  (HOLD_TICKS)
  ) u_blink (
    .Clock     (Clock),
    .RST       (RST),
    .tick      (frame_tick && (mode == MODE_OVER)),
    .clr       (frame_tick && (mode == MODE_PLAY) && hit),
    .phase     (phase),
    .hold_done (hold_done)
  );

  always_ff @(posedge Clock or posedge RST) begin
    if (RST) begin
      mode      <= MODE_START;
      redled    <= '0;
      greenled  <= '0;
      collision <= 1'b0;
      score     <= '0;
    end else begin
      collision <= 1'b0;
      case (mode)
        MODE_START: begin
          if (frame_tick) begin
            redled   <= START_IMG;
            greenled <= '0;
          end
          if (start_btn) begin
            mode  <= MODE_PLAY;
            score <= '0;
          end
        end
        MODE_PLAY: begin
          if (frame_tick) begin
            redled   <= play_red;
            greenled <= pipes;
            if (hit) begin
              mode      <= MODE_OVER;
              collision <= 1'b1;
            end else if (score != '1) begin
              score <= score + 1'b1;
            end
          end
        end
        MODE_OVER: begin
          if (frame_tick)
            redled <= phase ? '0 : OVER_IMG;
          // hold_done reflects the pre-increment count, so a start on the
          // tick that reaches HOLD_TICKS is rejected.
          if (start_btn && hold_done)
            mode <= MODE_START;
        end
        default: mode <= MODE_START;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Directed self-checking bench for led_frame_ctrl (8-bit and 3-bit score instances).
module tb_led_frame_ctrl;
  import flappy_pkg::*;

  logic                  Clock = 1'b0;
  logic                  RST;
  logic                  frame_tick;
  logic                  start_btn;
  logic [15:0]           birdie;
  logic [15:0][15:0]     pipes;
  logic [15:0][15:0]     redled, greenled, redled3, greenled3;
  mode_e                 mode, mode3;
  logic                  collision, collision3;
  logic [7:0]            score;
  logic [2:0]            score3;

  int vec  = 0;
  int miss = 0;

  logic [15:0][15:0] exp_red;
  logic [15:0][15:0] frozen;

  always #5 Clock = ~Clock;

  led_frame_ctrl #(.BIRD_ROW(2), .BLINK_TICKS(4), .HOLD_TICKS(8), .SCORE_W(8)) dut (
    .Clock(Clock), .RST(RST), .frame_tick(frame_tick), .start_btn(start_btn),
    .birdie(birdie), .pipes(pipes), .redled(redled), .greenled(greenled),
    .mode(mode), .collision(collision), .score(score)
  );

  led_frame_ctrl #(.BIRD_ROW(2), .BLINK_TICKS(4), .HOLD_TICKS(8), .SCORE_W(3)) dut3 (
    .Clock(Clock), .RST(RST), .frame_tick(frame_tick), .start_btn(start_btn),
    .birdie(birdie), .pipes(pipes), .redled(redled3), .greenled(greenled3),
    .mode(mode3), .collision(collision3), .score(score3)
  );

  // One clock cycle with the given inputs; returns at the following negedge.
  task automatic pulse(input logic tk, input logic sb);
    @(negedge Clock);
    frame_tick = tk;
    start_btn  = sb;
    @(negedge Clock);
    frame_tick = 1'b0;
    start_btn  = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1; frame_tick = 1'b0; start_btn = 1'b0; birdie = '0; pipes = '0;
    repeat (2) @(negedge Clock);
    vec++; if (mode !== MODE_START) begin miss++; $display("FAIL reset_mode got %0d want 0", mode); end
    vec++; if (redled !== '0 || greenled !== '0) begin miss++; $display("FAIL reset_planes red %h green %h want 0", redled, greenled); end
    vec++; if (score !== 8'd0 || collision !== 1'b0) begin miss++; $display("FAIL reset_score score %0d coll %b want 0 0", score, collision); end
    RST = 1'b0;
    repeat (3) pulse(1'b1, 1'b0);
    vec++; if (mode !== MODE_START) begin miss++; $display("FAIL start_mode got %0d want 0", mode); end
    vec++; if (redled !== START_IMG) begin miss++; $display("FAIL start_red got %h want %h", redled, START_IMG); end
    vec++; if (greenled !== '0 || score !== 8'd0) begin miss++; $display("FAIL start_green_score green %h score %0d want 0 0", greenled, score); end
  endtask

  task automatic test_play;
    pulse(1'b0, 1'b1);
    vec++; if (mode !== MODE_PLAY) begin miss++; $display("FAIL play_enter got %0d want 1", mode); end
    vec++; if (redled !== START_IMG) begin miss++; $display("FAIL play_no_tick_red got %h want %h", redled, START_IMG); end
    birdie = 16'h0100;
    for (int k = 0; k < 5; k++) begin
      for (int r = 0; r < 16; r++) pipes[r] = (r == 2) ? 16'h0000 : (16'hC003 ^ 16'(k << r));
      pulse(1'b1, 1'b0);
    end
    exp_red = '0; exp_red[2] = 16'h0100;
    vec++; if (mode !== MODE_PLAY) begin miss++; $display("FAIL play_mode got %0d want 1", mode); end
    vec++; if (redled !== exp_red) begin miss++; $display("FAIL play_red got %h want %h", redled, exp_red); end
    vec++; if (greenled !== pipes) begin miss++; $display("FAIL play_green got %h want %h", greenled, pipes); end
    vec++; if (score !== 8'd5 || score3 !== 3'd5) begin miss++; $display("FAIL play_score got %0d/%0d want 5/5", score, score3); end
    // start_btn in PLAY must be ignored
    pulse(1'b0, 1'b1);
    vec++; if (mode !== MODE_PLAY) begin miss++; $display("FAIL play_start_ignored got %0d want 1", mode); end
  endtask

  task automatic test_collision;
    pipes[2] = 16'h0100;
    frozen = pipes;
    pulse(1'b1, 1'b0);
    vec++; if (collision !== 1'b1) begin miss++; $display("FAIL coll_pulse got %b want 1", collision); end
    vec++; if (mode !== MODE_OVER) begin miss++; $display("FAIL coll_mode got %0d want 2", mode); end
    vec++; if (score !== 8'd5) begin miss++; $display("FAIL coll_score got %0d want 5", score); end
    vec++; if (redled !== exp_red || greenled !== frozen) begin miss++; $display("FAIL coll_frame red %h green %h", redled, greenled); end
    @(negedge Clock);
    vec++; if (collision !== 1'b0) begin miss++; $display("FAIL coll_one_cycle got %b want 0", collision); end
  endtask

  task automatic test_over_blink;
    logic [15:0][15:0] want;
    for (int k = 1; k <= 12; k++) begin
      for (int r = 0; r < 16; r++) pipes[r] = 16'(16'h5A5A + k * r);
      pulse(1'b1, (k == 3) || (k == 8));
      want = (k <= 4 || k >= 9) ? OVER_IMG : '0;
      vec++; if (redled !== want) begin miss++; $display("FAIL blink_tick%0d got %h want %h", k, redled, want); end
      vec++; if (mode !== MODE_OVER) begin miss++; $display("FAIL over_hold_tick%0d mode %0d want 2", k, mode); end
      vec++; if (greenled !== frozen) begin miss++; $display("FAIL green_frozen_tick%0d got %h want %h", k, greenled, frozen); end
      vec++; if (score !== 8'd5) begin miss++; $display("FAIL over_score_tick%0d got %0d want 5", k, score); end
    end
    pulse(1'b0, 1'b1);
    vec++; if (mode !== MODE_START) begin miss++; $display("FAIL over_exit got %0d want 0", mode); end
    vec++; if (redled !== OVER_IMG) begin miss++; $display("FAIL over_exit_red got %h want %h", redled, OVER_IMG); end
  endtask

  task automatic test_saturate;
    pipes = '0;
    birdie = 16'h0001;
    pulse(1'b1, 1'b1);
    vec++; if (redled !== START_IMG) begin miss++; $display("FAIL simul_red got %h want %h", redled, START_IMG); end
    vec++; if (mode !== MODE_PLAY || score !== 8'd0) begin miss++; $display("FAIL simul_mode mode %0d score %0d want 1 0", mode, score); end
    for (int k = 1; k <= 10; k++) begin
      birdie = 16'(1 << k);
      pulse(1'b1, 1'b0);
      if (k == 7) begin
        vec++; if (score3 !== 3'd7) begin miss++; $display("FAIL sat_reach got %0d want 7", score3); end
      end
    end
    exp_red = '0; exp_red[2] = 16'h0400;
    vec++; if (score3 !== 3'd7) begin miss++; $display("FAIL sat_hold got %0d want 7", score3); end
    vec++; if (score !== 8'd10) begin miss++; $display("FAIL score_wide got %0d want 10", score); end
    vec++; if (redled !== exp_red) begin miss++; $display("FAIL sat_red got %h want %h", redled, exp_red); end
  endtask

  task automatic test_reset_midplay;
    @(negedge Clock);
    #2 RST = 1'b1;
    #1;
    vec++; if (redled !== '0 || greenled !== '0) begin miss++; $display("FAIL async_planes red %h green %h want 0", redled, greenled); end
    vec++; if (mode !== MODE_START || score !== 8'd0 || score3 !== 3'd0) begin miss++; $display("FAIL async_state mode %0d score %0d/%0d want 0", mode, score, score3); end
    @(negedge Clock);
    RST = 1'b0;
  endtask

  initial begin
    fork
      begin
        test_reset;
        test_play;
        test_collision;
        test_over_blink;
        test_saturate;
        test_reset_midplay;
      end
      begin
        #100000;
        miss++;
        $display("FAIL timeout reached at %0t want completion", $time);
      end
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
